// File: rtl/dna_port_responder.sv
// Purpose : device-side DNA_PORT responder; serves a 57-bit identifier over the
//           reader-driven DNA clock and reports shift progress and protocol errors.
// Latency : registers update on the clk edge ending a DNA-clock tick cycle;
//           dout_o is valid one clk after that tick.
// Backpressure: none. Each rising DNA-clock edge is consumed immediately.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   dna_clk_i            reader DNA clock (level, synchronous to clk)
//   read_i, shift_i      READ / SHIFT requests, sampled on a DNA-clock rising edge
//   din_i                serial input, enters the MSB on each shift
//   dout_o               serial output, LSB of the shift register
//   id_override_valid_i  selects id_i instead of DNA_DEFAULT at load time
//   id_i                 override identifier
//   loaded_o             an identifier has been loaded since reset
//   bit_count_o          shifts since last load, saturating
//   exhausted_o          DNA_WIDTH or more shifts since last load
//   protocol_err_o       sticky protocol-violation flag
module dna_port_responder #(
  parameter int                   DNA_WIDTH   = 57,
  parameter logic [DNA_WIDTH-1:0] DNA_DEFAULT = 57'h0_1234_5678_9ABC_DE,
  parameter int                   CNT_WIDTH   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dna_clk_i,
  input  logic                 read_i,
  input  logic                 shift_i,
  input  logic                 din_i,
  output logic                 dout_o,
  input  logic                 id_override_valid_i,
  input  logic [DNA_WIDTH-1:0] id_i,
  output logic                 loaded_o,
  output logic [CNT_WIDTH-1:0] bit_count_o,
  output logic                 exhausted_o,
  output logic                 protocol_err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DNA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOADED    = 2'd1,
    S_SHIFTING  = 2'd2,
    S_EXHAUSTED = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   dna_clk_q;
  logic                   tick;
  logic                   do_load;
  logic                   do_shift;
  logic                   advance;
  logic                   err_set;
  logic [DNA_WIDTH-1:0]   sr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   err;

  // Rising-edge detect on the reader clock; a held-high level yields one tick.
  assign tick     = dna_clk_i & ~dna_clk_q;
  // READ has priority over SHIFT when both are requested on the same tick.
  assign do_load  = tick & read_i;
  assign do_shift = tick & shift_i & ~read_i;
  // The counter only tracks shifts of a loaded identifier; IDLE shifts are errors.
  assign advance  = do_shift & (state != S_IDLE);
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign err_set  = (tick & read_i & shift_i) | (do_shift & (state == S_IDLE));

  // Data path: edge-detect flop and shift register. Independent of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dna_clk_q <= 1'b0;
      sr        <= '0;
    end else begin
      dna_clk_q <= dna_clk_i;
      if (do_load) begin
        sr <= id_override_valid_i ? id_i : DNA_DEFAULT;
      end else if (do_shift) begin
        sr <= {din_i, sr[DNA_WIDTH-1:1]};
      end
    end
  end

  // Shift counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (do_load) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt_inc;
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic. Exhaustion is judged on the post-shift count so
  // exhausted_o rises on the same edge that bit_count_o reaches DNA_WIDTH.
  always_comb begin
    state_nxt = state;
    if (do_load) begin
      state_nxt = S_LOADED;
    end else if (advance) begin
      if (cnt_inc >= CNT_FULL) begin
        state_nxt = S_EXHAUSTED;
      end else begin
        state_nxt = S_SHIFTING;
      end
    end
  end

  // FSM: status outputs, decoded from the registered state.
  always_comb begin
    loaded_o    = 1'b0;
    exhausted_o = 1'b0;
    case (state)
      S_IDLE:      begin loaded_o = 1'b0; exhausted_o = 1'b0; end
      S_LOADED:    begin loaded_o = 1'b1; exhausted_o = 1'b0; end
      S_SHIFTING:  begin loaded_o = 1'b1; exhausted_o = 1'b0; end
      S_EXHAUSTED: begin loaded_o = 1'b1; exhausted_o = 1'b1; end
      default:     begin loaded_o = 1'b0; exhausted_o = 1'b0; end
    endcase
  end

  assign dout_o         = sr[0];
  assign bit_count_o    = cnt;
  assign protocol_err_o = err;

endmodule

// File: tb/tb_dna_port_responder.sv
// Purpose : self-checking bench for dna_port_responder against a bit-queue model.
// Latency : model state is advanced on each clk rising edge; outputs are compared on falling edges.
// Backpressure: not applicable.
module tb_dna_port_responder;

  localparam int W  = 57;
  localparam int CW = 7;
  localparam logic [W-1:0] DEF = 57'h0_1234_5678_9ABC_DE;
  localparam logic [W-1:0] OVR = 57'h1_FFFF_0000_AAAA_55;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dna_clk_i = 1'b0;
  logic          read_i = 1'b0;
  logic          shift_i = 1'b0;
  logic          din_i = 1'b0;
  logic          dout_o;
  logic          id_override_valid_i = 1'b0;
  logic [W-1:0]  id_i = '0;
  logic          loaded_o;
  logic [CW-1:0] bit_count_o;
  logic          exhausted_o;
  logic          protocol_err_o;

  dna_port_responder #(.DNA_WIDTH(W), .DNA_DEFAULT(DEF), .CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dna_clk_i           (dna_clk_i),
    .read_i              (read_i),
    .shift_i             (shift_i),
    .din_i               (din_i),
    .dout_o              (dout_o),
    .id_override_valid_i (id_override_valid_i),
    .id_i                (id_i),
    .loaded_o            (loaded_o),
    .bit_count_o         (bit_count_o),
    .exhausted_o         (exhausted_o),
    .protocol_err_o      (protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: identifier as a queue of bits, LSB at the front.
  bit mq[$];
  int m_cnt    = 0;
  bit m_loaded = 1'b0;
  bit m_err    = 1'b0;
  bit m_prev   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_fill(input logic [W-1:0] v);
    mq.delete();
    for (int i = 0; i < W; i++) mq.push_back(v[i]);
  endtask

  // Applies the protocol rules to the inputs present at this clk rising edge.
  task automatic model_edge();
    if (rst) begin
      model_fill('0);
      m_cnt = 0; m_loaded = 0; m_err = 0; m_prev = 0;
    end else begin
      if (dna_clk_i && !m_prev) begin
        if (read_i) begin
          model_fill(id_override_valid_i ? id_i : DEF);
          m_cnt = 0;
          m_loaded = 1;
          if (shift_i) m_err = 1;
        end else if (shift_i) begin
          void'(mq.pop_front());
          mq.push_back(din_i);
          if (!m_loaded) m_err = 1;
          else if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
      m_prev = dna_clk_i;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One DNA clock period: high for one clk (the tick), then low for one clk.
  task automatic dtick(input logic r, input logic s, input logic d);
    read_i = r; shift_i = s; din_i = d; dna_clk_i = 1'b1;
    cyc();
    dna_clk_i = 1'b0; read_i = 1'b0; shift_i = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; dna_clk_i = 1'b0; read_i = 1'b0; shift_i = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout",      64'(dout_o),         64'(mq[0]));
      chk("bit_count", 64'(bit_count_o),    64'(m_cnt));
      chk("loaded",    64'(loaded_o),       64'(m_loaded));
      chk("exhausted", 64'(exhausted_o),    64'(m_loaded && m_cnt >= W));
      chk("proto_err", 64'(protocol_err_o), 64'(m_err));
    end
  end

  initial begin
    logic [63:0]  cap;
    logic [W-1:0] defv;
    logic [W-1:0] ovrv;
    defv = DEF;
    ovrv = OVR;
    model_fill('0);

    // Reset state.
    do_reset();
    chk_en = 1'b1;
    chk("rst_loaded", 64'(loaded_o), 64'd0);
    chk("rst_count",  64'(bit_count_o), 64'd0);
    chk("rst_dout",   64'(dout_o), 64'd0);

    // Default load.
    dtick(1'b1, 1'b0, 1'b0);
    chk("load_dout",   64'(dout_o), 64'(defv[0]));
    chk("load_loaded", 64'(loaded_o), 64'd1);
    chk("load_count",  64'(bit_count_o), 64'd0);

    // Read out the default identifier.
    cap = '0;
    cap[0] = dout_o;
    for (int k = 1; k < W; k++) begin
      dtick(1'b0, 1'b1, 1'b0);
      cap[k] = dout_o;
    end
    dtick(1'b0, 1'b1, 1'b0);
    chk("default_word",  cap, 64'h0123456789ABCDE);
    chk("default_count", 64'(bit_count_o), 64'd57);
    chk("default_exh",   64'(exhausted_o), 64'd1);

    // Override load, read out, then observe shifted-in ones.
    id_override_valid_i = 1'b1; id_i = ovrv;
    dtick(1'b1, 1'b0, 1'b0);
    id_override_valid_i = 1'b0; id_i = '0;
    cap = '0;
    cap[0] = dout_o;
    for (int k = 1; k < W; k++) begin
      dtick(1'b0, 1'b1, 1'b1);
      cap[k] = dout_o;
    end
    chk("override_word", cap, 64'h1FFFF0000AAAA55);
    for (int k = 0; k < 3; k++) begin
      dtick(1'b0, 1'b1, 1'b1);
      chk("tail_ones", 64'(dout_o), 64'd1);
    end
    dtick(1'b0, 1'b1, 1'b1);
    chk("override_count", 64'(bit_count_o), 64'd60);
    chk("override_exh",   64'(exhausted_o), 64'd1);

    // Simultaneous READ and SHIFT: load wins, sticky error.
    dtick(1'b1, 1'b1, 1'b0);
    chk("both_count", 64'(bit_count_o), 64'd0);
    chk("both_err",   64'(protocol_err_o), 64'd1);
    chk("both_dout",  64'(dout_o), 64'(defv[0]));
    repeat (10) dtick(1'b0, 1'b0, 1'b0);
    chk("err_sticky", 64'(protocol_err_o), 64'd1);
    chk("idle_count", 64'(bit_count_o), 64'd0);

    // Shift while never loaded.
    do_reset();
    dtick(1'b0, 1'b1, 1'b1);
    chk("idle_err",    64'(protocol_err_o), 64'd1);
    chk("idle_loaded", 64'(loaded_o), 64'd0);
    chk("idle_cnt",    64'(bit_count_o), 64'd0);

    // DNA clock held high: a single shift.
    dtick(1'b1, 1'b0, 1'b0);
    shift_i = 1'b1; dna_clk_i = 1'b1;
    repeat (20) cyc();
    shift_i = 1'b0; dna_clk_i = 1'b0;
    cyc();
    chk("held_high", 64'(bit_count_o), 64'd1);

    // Reset coincident with a shift tick at count 30.
    do_reset();
    dtick(1'b1, 1'b0, 1'b0);
    repeat (30) dtick(1'b0, 1'b1, 1'b1);
    chk("pre_rst_count", 64'(bit_count_o), 64'd30);
    rst = 1'b1; shift_i = 1'b1; dna_clk_i = 1'b1;
    cyc();
    chk("rst_mid_count",  64'(bit_count_o), 64'd0);
    chk("rst_mid_dout",   64'(dout_o), 64'd0);
    chk("rst_mid_loaded", 64'(loaded_o), 64'd0);
    chk("rst_mid_exh",    64'(exhausted_o), 64'd0);
    rst = 1'b0; shift_i = 1'b0; dna_clk_i = 1'b0;
    cyc();

    // Random phase 1: irregular DNA clock, frequent reloads, id_i wiggling.
    repeat (3000) begin
      rst                 = ($urandom_range(0, 199) == 0);
      dna_clk_i           = 1'($urandom);
      read_i              = ($urandom_range(0, 7) == 0);
      shift_i             = ($urandom_range(0, 3) != 0);
      din_i               = 1'($urandom);
      id_override_valid_i = 1'($urandom);
      id_i                = W'({$urandom, $urandom});
      cyc();
    end

    // Random phase 2: regular DNA clock, rare reloads, reaches saturation.
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst                 = ($urandom_range(0, 1999) == 0);
      dna_clk_i           = i[0];
      read_i              = ($urandom_range(0, 399) == 0);
      shift_i             = ($urandom_range(0, 9) != 0);
      din_i               = 1'($urandom);
      id_override_valid_i = 1'($urandom);
      id_i                = W'({$urandom, $urandom});
      cyc();
    end
    rst = 1'b0; dna_clk_i = 1'b0; read_i = 1'b0; shift_i = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dna_port_responder.md
Name: dna_port_responder

Overview:
Synthesizable, single-clock responder for the FPGA DNA_PORT serial protocol: the device-side counterpart of the DNA reader. It answers READ/SHIFT requests on a reader-driven DNA clock with a programmable 57-bit identifier. It is used in simulation benches and on targets without a DNA_PORT primitive, so the reader and its checkers can run end to end. It also exports shift-progress and protocol-violation status for bench scoreboarding.

Parameters:
DNA_WIDTH, 57, identifier length in bits (2..64)
DNA_DEFAULT, 57'h0_1234_5678_9ABC_DE, identifier loaded when no override is valid
CNT_WIDTH, 7, width of shift counter; must satisfy 2**CNT_WIDTH > DNA_WIDTH

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
dna_clk_i  input  1  DNA clock from the reader, level, synchronous to clk
read_i  input  1  DNA READ: parallel-load request, sampled on dna_clk_i rising edge
shift_i  input  1  DNA SHIFT: shift request, sampled on dna_clk_i rising edge
din_i  input  1  serial input shifted into the MSB on each shift
dout_o  output  1  serial output, LSB of the shift register
id_override_valid_i  input  1  when high at load time, id_i replaces DNA_DEFAULT
id_i  input  DNA_WIDTH  override identifier
loaded_o  output  1  register holds a loaded identifier
bit_count_o  output  CNT_WIDTH  shifts performed since the last load, saturating
exhausted_o  output  1  DNA_WIDTH or more shifts done since load
protocol_err_o  output  1  sticky protocol-violation flag

Behaviour:
- Reset is synchronous. While rst=1, on each clk edge: shift register=0, dna_clk_q=0, dout_o=0, loaded_o=0, bit_count_o=0, exhausted_o=0, protocol_err_o=0, FSM=IDLE.
- Edge detect: dna_clk_q registers dna_clk_i. tick = dna_clk_i & ~dna_clk_q. read_i, shift_i and din_i are sampled in the tick cycle.
- All register updates take effect on the clk edge that ends the tick cycle.
- dout_o is a registered output equal to sr[0], so it is valid one clk after the tick. The reader must not sample before its next DNA clock edge.
- Load (tick & read_i): sr <= id_override_valid_i ? id_i : DNA_DEFAULT; bit_count_o <= 0; loaded_o <= 1; exhausted_o <= 0; FSM -> LOADED.
- Shift (tick & shift_i & ~read_i): sr <= {din_i, sr[DNA_WIDTH-1:1]}. bit_count_o increments and saturates at 2**CNT_WIDTH-1.
- Shift to exhaustion: when bit_count_o reaches DNA_WIDTH, exhausted_o <= 1 and FSM -> EXHAUSTED. Further shifts still move data, so din_i bits appear on dout_o after DNA_WIDTH shifts.
- Priority: read_i and shift_i both high at a tick -> load wins; protocol_err_o <= 1.
- Shift in IDLE (never loaded): the register shifts, but protocol_err_o <= 1, loaded_o stays 0, and the counter does not advance.
- A tick with read_i=shift_i=0 leaves all state unchanged.
- dna_clk_i held high produces no repeated ticks; only a rising edge counts.
- Reload at any point (LOADED/SHIFTING/EXHAUSTED) restarts cleanly from the new identifier.
- FSM states: IDLE -(load)-> LOADED -(shift)-> SHIFTING -(count==DNA_WIDTH)-> EXHAUSTED. Any state goes to LOADED on load; rst forces IDLE.
- FSM state affects status outputs only, never the data path.
- protocol_err_o is sticky and cleared only by rst.
- Reset mid-shift: rst wins over a coincident tick; all outputs return to reset values on that edge.
- id_i is sampled only at the load tick; later changes to id_i do not affect the register.

Test Plan:
- Reset, then tick with read_i=1, no override -> next cycle dout_o=DNA_DEFAULT[0]=0, loaded_o=1, bit_count_o=0.
- Load DNA_DEFAULT, then 57 shift ticks with din_i=0, capturing dout_o after each tick -> reconstructed word = 57'h0_1234_5678_9ABC_DE; bit_count_o=57; exhausted_o=1.
- Load with id_override_valid_i=1, id_i=57'h1_FFFF_0000_AAAA_55, then 57 shifts with din_i=1, then 3 more shifts -> first 57 bits read equal the override; next 3 reads=1; bit_count_o=60.
- Tick with read_i=1 and shift_i=1 -> identifier reloaded, bit_count_o=0, protocol_err_o=1 and still 1 after 10 idle ticks.
- Shift tick in IDLE after reset -> protocol_err_o=1, loaded_o=0, bit_count_o=0. Hold dna_clk_i high for 20 clk with shift_i=1 -> exactly one shift.
- Assert rst in the same cycle as a shift tick at bit_count_o=30 -> next cycle bit_count_o=0, dout_o=0, loaded_o=0, exhausted_o=0.
